updown_counter_mod: RTL

- Parametrised successor of the team's 4-bit loadable up/down counter (din/load/ud/count).
- Generalised in width and modulus; selectable wrap or saturate mode.
- Adds count enable, a terminal-count pulse, sticky overflow/underflow flags with clear, load range checking and a compare-match output.
- Sits as the DUT behind the counter UVM environment; write agents drive the control inputs, the read monitor samples count and status.

---
 rtl/updown_counter_mod.sv | 131 +++++++++++++
 1 files changed

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised loadable up/down counter with wrap or saturate
// boundaries, terminal-count pulse, sticky overflow/underflow flags and compare match.
module updown_counter_mod #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SAT_MODE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ud,
  input  logic             clr_flags,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             load_err,
  output logic             match
);

  if ((WIDTH < 32'sd1) || (WIDTH > 32'sd32)) begin : g_bad_width
    $error("updown_counter_mod: WIDTH must be within 1..32");
  end

  if ((MAX_VAL < 64'd1) || (MAX_VAL > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_max
    $error("updown_counter_mod: MAX_VAL must be within 1..2**WIDTH-1");
  end

  localparam logic [WIDTH:0]   MAX_EXT = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_CNT = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic             ovf_r;
  logic             unf_r;
  logic             load_err_r;

  logic [WIDTH:0]   cnt_ext_s;
  logic [WIDTH:0]   inc_s;
  logic [WIDTH:0]   dec_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             tc_nxt_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;
  logic             load_err_nxt_s;

  // One extra bit keeps the carry when MAX_VAL is the full 2**WIDTH-1 range;
  // the borrow bit of dec_s flags a decrement from zero.
  assign cnt_ext_s = {1'b0, count_r};
  assign inc_s     = cnt_ext_s + {{WIDTH{1'b0}}, 1'b1};
  assign dec_s     = cnt_ext_s - {{WIDTH{1'b0}}, 1'b1};

  // Next-state: load beats count, boundaries raise tc and the sticky-flag set terms.
  always_comb begin
    count_nxt_s    = count_r;
    tc_nxt_s       = 1'b0;
    ovf_set_s      = 1'b0;
    unf_set_s      = 1'b0;
    load_err_nxt_s = 1'b0;
    if (load) begin
      if ({1'b0, din} > MAX_EXT) begin
        count_nxt_s    = MAX_CNT;
        load_err_nxt_s = 1'b1;
      end else begin
        count_nxt_s    = din;
      end
    end else if (en) begin
      if (ud) begin
        if (inc_s > MAX_EXT) begin
          tc_nxt_s  = 1'b1;
          ovf_set_s = 1'b1;
          if (SAT_MODE) begin
            count_nxt_s = MAX_CNT;
          end else begin
            count_nxt_s = {WIDTH{1'b0}};
          end
        end else begin
          count_nxt_s = inc_s[WIDTH-1:0];
        end
      end else begin
        if (dec_s[WIDTH]) begin
          tc_nxt_s  = 1'b1;
          unf_set_s = 1'b1;
          if (SAT_MODE) begin
            count_nxt_s = {WIDTH{1'b0}};
          end else begin
            count_nxt_s = MAX_CNT;
          end
        end else begin
          count_nxt_s = dec_s[WIDTH-1:0];
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
    // A new boundary event outranks a simultaneous clear.
    ovf_nxt_s = ovf_set_s | (ovf_r & ~clr_flags);
    unf_nxt_s = unf_set_s | (unf_r & ~clr_flags);
  end

  // State register with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r    <= {WIDTH{1'b0}};
      tc_r       <= 1'b0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      tc_r       <= tc_nxt_s;
      ovf_r      <= ovf_nxt_s;
      unf_r      <= unf_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign count    = count_r;
  assign tc       = tc_r;
  assign ovf      = ovf_r;
  assign unf      = unf_r;
  assign load_err = load_err_r;
  // count never exceeds MAX_VAL, so an out-of-range cmp_val cannot match.
  assign match    = (count_r == cmp_val);

endmodule
